clz_sched: RTL and testbench
============================

# clz_sched

Sequencer and two-port arbiter around the CPU's count-leading-zeros datapath, so the ALU CLZ/CLO path and the divider's normalization step share one scan unit. It accepts one operation at a time from either requester using a valid/ready handshake, and grants round-robin when both requesters ask in the same cycle. CLO is implemented by inverting the operand before the scan. It registers both the operand and the result, and holds the response until the owning requester accepts it.

## Interface
- No parameters. The operand width is fixed at 32 bits and the result range is 0..32.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 (ALU) has a request.
- req0_op  in  1  0 = CLZ, 1 = CLO.
- req0_data  in  32  operand.
- req0_ready  out  1  port 0 request is accepted this cycle.
- rsp0_valid  out  1  port 0 result is available.
- rsp0_data  out  32  port 0 result, zero-extended count.
- rsp0_ready  in  1  port 0 consumes the result.
- req1_valid, req1_op, req1_data, req1_ready, rsp1_valid, rsp1_data, rsp1_ready: same as port 0, for port 1 (divider).
- busy  out  1  high when the state is not IDLE.

## Operation
- States: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - Compute grant from the valid inputs and last_grant. A single valid requester always wins.
  - If both are valid, the port other than last_grant wins.
  - req*_ready of the granted port = 1 in the same cycle; the non-granted port's ready = 0.
  - If no requester is valid, both readies = 0 and the state stays IDLE.
- Accept (valid & ready at the edge):
  - opnd_r <= op ? ~data : data.
  - owner_r <= granted port.
  - last_grant <= granted port.
  - Next state is CALC.
- CALC:
  - res_r <= leading-zero count of opnd_r: the index distance from bit 31 to the first 1.
  - If opnd_r == 0, res_r = 32.
  - Next state is RESP unconditionally.
- RESP:
  - rsp{owner_r}_valid = 1 and rsp{owner_r}_data = {26'b0, res_r}.
  - The other port's rsp_valid = 0.
  - Stay in RESP while rsp{owner_r}_ready = 0. Data must stay stable.
  - On rsp{owner_r}_ready = 1, go to IDLE. No new request is accepted in that same cycle.
- The rsp_ready of the non-owner port is ignored in every state.
- req*_ready = 0 in CALC and RESP. A requester may hold valid and change data freely; the operand is sampled only at accept.
- Reset-time last_grant = 1, so port 0 wins the first simultaneous request.
- Width rule: the count is 6 bits internally (0..32) and the upper output bits are always 0.

## Timing
- Reset (async, rst_n low) clears everything immediately, even mid-CALC or mid-RESP:
  - state = IDLE, opnd_r = 0, res_r = 0, owner_r = 0, last_grant = 1.
  - All rsp*_valid = 0, all req*_ready = 0 (no valid present), busy = 0.
  - Any in-flight operation is discarded and no response is produced.
- Latency:
  - Request accepted at edge E.
  - CALC occupies cycle E..E+1.
  - rsp_valid is high from edge E+2.
- Throughput: at most one operation per 3 cycles with rsp_ready held at 1 (accept, calc, respond, then back to IDLE).
- busy goes high the cycle after accept and falls the cycle after the response handshake.
- req*_ready is combinational from req*_valid and state; rsp* outputs are purely registered or state-decoded.
- Simultaneous valid on both ports with last_grant = 0: port 1 wins, and port 0's valid must be honored on the next IDLE visit.

## Test plan
- Reset: assert rst_n = 0 mid-CALC.
  - Required: busy, rsp0_valid, rsp1_valid, req0_ready and req1_ready all 0 immediately.
  - Required after release: the next request is served normally.
- Port 0 CLZ, data 0x00010000, rsp0_ready = 1.
  - Required: rsp0_data = 15, exactly 2 cycles after accept.
  - Required: rsp1_valid stays 0 throughout.
- Boundary values:
  - Port 1 CLZ of 0x00000000: rsp1_data = 32.
  - CLO of 0xFFFFFFFF: rsp1_data = 32.
  - CLZ of 0x80000000: 0.
  - CLO of 0x7FFFFFFF: 0.
  - CLO of 0xFFFF0000: 16.
- Both ports valid continuously for 4 operations, starting from reset.
  - Required grant order: 0, 1, 0, 1.
  - Required: each result returns on the correct rsp port.
- Backpressure: hold rsp0_ready = 0 for 5 cycles during RESP.
  - Required: rsp0_valid and rsp0_data stay stable.
  - Required: req1_ready stays 0 despite req1_valid = 1.
  - Required: port 1 is granted in the cycle after the handshake.
- Operand sampling: change req0_data after accept.
  - Required: the result reflects the value sampled at accept only.

Source files
------------

// File: rtl/clz_sched.sv
// Two-port round-robin sequencer around a single 32-bit count-leading-zeros/ones scan unit.
// Latency: accept cycle, one CALC cycle, then the response is presented in RESP (3 cycles per op minimum).
// Backpressure: response held stable in RESP until the owner's rsp_ready; no request is accepted outside IDLE.
module clz_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_op,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        rsp0_ready,
  input  logic        req1_valid,
  input  logic        req1_op,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        rsp1_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] opnd_r;
  logic [5:0]  res_r;
  logic        owner_r;
  logic        last_grant;

  logic        any_vld;
  logic        gnt;
  logic        accept;
  logic        rsp_hs;
  logic [5:0]  cnt;

  // Arbitration: a lone requester wins; on contention the port not granted last time wins.
  always_comb begin
    any_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt = ~last_grant;
    end else begin
      gnt = req1_valid;
    end
    accept = (state == IDLE) && any_vld;
    rsp_hs = (state == RESP) && (owner_r ? rsp1_ready : rsp0_ready);
  end

  // Leading-zero scan of the registered operand; the highest set bit wins, all-zero gives 32.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (opnd_r[i]) begin
        cnt = 6'(31 - i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> CALC on accept, CALC -> RESP always, RESP -> IDLE on owner handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: readies only in IDLE for the granted port, response valid only toward the owner.
  always_comb begin
    req0_ready = (state == IDLE) && req0_valid && !gnt;
    req1_ready = (state == IDLE) && req1_valid && gnt;
    rsp0_valid = (state == RESP) && !owner_r;
    rsp1_valid = (state == RESP) && owner_r;
    rsp0_data  = {26'b0, res_r};
    rsp1_data  = {26'b0, res_r};
    busy       = (state != IDLE);
  end

  // Operand capture at accept (inverted for CLO) and result capture in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_r     <= 32'd0;
      res_r      <= 6'd0;
      owner_r    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        if (gnt) begin
          opnd_r <= req1_op ? ~req1_data : req1_data;
        end else begin
          opnd_r <= req0_op ? ~req0_data : req0_data;
        end
        owner_r    <= gnt;
        last_grant <= gnt;
      end
      if (state == CALC) begin
        res_r <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_clz_sched.sv
// Directed bench for clz_sched: vector table of single operations plus reset, arbitration and backpressure sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge (or #1 after an input change).
// Each response is expected two rising edges after the accepting edge's cycle began.
module tb_clz_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_op, req0_ready;
  logic [31:0] req0_data;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data;
  logic        req1_valid, req1_op, req1_ready;
  logic [31:0] req1_data;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  clz_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_ready (rsp0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_ready (rsp1_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          op;
    logic [31:0] data;
    int          exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One isolated operation on one port with rsp_ready held high.
  task automatic run_op(input bit port, input bit op, input logic [31:0] d, input int exp, input string nm);
    int n;
    @(negedge clk);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_data = d;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " req_ready"}, port ? req1_ready : req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // operand changes after accept must not affect the result
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = ~d;    req1_data = ~d;
    n = 1;
    while (!(port ? rsp1_valid : rsp0_valid) && n < 20) begin
      @(negedge clk); n++;
    end
    chk({nm, " latency"}, n, 2);
    chk({nm, " result"}, port ? rsp1_data : rsp0_data, exp);
    chk({nm, " other rsp_valid"}, port ? rsp0_valid : rsp1_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " busy after handshake"}, busy, 0);
  endtask

  initial begin
    int n;
    bit g;

    vecs[0] = '{1'b0, 1'b0, 32'h0001_0000, 15};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0000, 32};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32};
    vecs[3] = '{1'b0, 1'b0, 32'h8000_0000, 0};
    vecs[4] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 0};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_0000, 16};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0001, 31};
    vecs[7] = '{1'b0, 1'b0, 32'h0080_0000, 8};
    vecs[8] = '{1'b1, 1'b1, 32'hF000_0000, 4};
    vecs[9] = '{1'b0, 1'b1, 32'h0000_0000, 0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 1'b0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_data = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset rsp0_valid", rsp0_valid, 0);
    chk("reset rsp1_valid", rsp1_valid, 0);
    chk("reset rsp0_data", rsp0_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted while an operation is in CALC.
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h0000_00F0;
    #1;
    chk("midcalc accept ready", req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("midcalc busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midcalc reset busy", busy, 0);
    chk("midcalc reset rsp0_valid", rsp0_valid, 0);
    chk("midcalc reset rsp1_valid", rsp1_valid, 0);
    chk("midcalc reset req0_ready", req0_ready, 0);
    chk("midcalc reset req1_ready", req1_ready, 0);
    @(negedge clk);
    chk("midcalc held rsp0_valid", rsp0_valid, 0);
    rst_n = 1'b1;

    // Table of single operations, also covers service after the mid-CALC reset.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].port, vecs[i].op, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Both ports continuously valid from reset: grants must alternate 0,1,0,1.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h0001_0000;
    req1_valid = 1'b1; req1_op = 1'b0; req1_data = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk($sformatf("rr%0d some ready", k), req0_ready | req1_ready, 1);
      chk($sformatf("rr%0d single ready", k), req0_ready & req1_ready, 0);
      g = req1_ready;
      chk($sformatf("rr%0d grant", k), g, k % 2);
      @(posedge clk);
      @(negedge clk);
      n = 0;
      while (!(rsp0_valid || rsp1_valid) && n < 20) begin
        @(negedge clk); n++;
      end
      chk($sformatf("rr%0d rsp port", k), rsp1_valid, g);
      chk($sformatf("rr%0d rsp data", k), g ? rsp1_data : rsp0_data, g ? 23 : 15);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on port 0 while port 1 waits.
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 32'h0000_0800;
    #1;
    chk("bp accept ready", req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req0_data = 32'hFFFF_FFFF;
    req1_valid = 1'b1; req1_op = 1'b1; req1_data = 32'h0000_0001;
    #1;
    chk("bp calc req1_ready", req1_ready, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d rsp0_valid", c), rsp0_valid, 1);
      chk($sformatf("bp%0d rsp0_data", c), rsp0_data, 20);
      chk($sformatf("bp%0d req1_ready", c), req1_ready, 0);
      chk($sformatf("bp%0d rsp1_valid", c), rsp1_valid, 0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp handshake req1_ready", req1_ready, 0);
    @(negedge clk);
    chk("bp after rsp0_valid", rsp0_valid, 0);
    chk("bp after req1_ready", req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    n = 0;
    while (!rsp1_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("bp port1 rsp valid", rsp1_valid, 1);
    chk("bp port1 rsp data", rsp1_data, 0);
    @(negedge clk);
    chk("bp final busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
